// File: rtl/aes_pkg.sv
// Shared types and header-field layout for the AES command packer.
package aes_pkg;

  localparam int DEF_WORD_W = 32;
  localparam int DEF_DATA_W = 256;
  localparam int DEF_OPC_W  = 5;

  localparam int HDR_OPC_LSB = 0;
  localparam int HDR_NW_LSB  = 8;
  localparam int HDR_NW_W    = 4;
  localparam int MAX_WORDS   = DEF_DATA_W / DEF_WORD_W;

  typedef logic [DEF_OPC_W-1:0] opcode_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ISSUE
  } pack_state_t;

endpackage

// File: rtl/aes_cmd_packer.sv
// Assembles a header + payload host word stream into one opcode/operand command
// and offers it to the AES core over a valid/ready handshake.
module aes_cmd_packer
  import aes_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int OPC_W  = DEF_OPC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic [WORD_W-1:0] word_data,
  output logic              input_valid,
  input  logic              input_ready,
  output logic [OPC_W-1:0]  opcode,
  output logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              err
);

  localparam int                  LANES  = DATA_W / WORD_W;
  localparam logic [HDR_NW_W-1:0] MAX_NW = HDR_NW_W'(LANES);

  pack_state_t         state, state_next;
  logic [HDR_NW_W-1:0] count;
  logic [HDR_NW_W-1:0] nwords;
  logic [OPC_W-1:0]    opcode_q;
  logic [DATA_W-1:0]   data_q;
  logic                input_valid_q;
  logic                err_q;

  logic                word_fire;
  logic                last_word;
  logic                hdr_bad;
  logic                hdr_take;
  logic [HDR_NW_W-1:0] hdr_nw;

  assign hdr_nw     = word_data[HDR_NW_LSB +: HDR_NW_W];
  assign word_ready = (state != ISSUE);
  assign word_fire  = word_valid && word_ready;
  assign last_word  = (count == nwords - 1'b1);
  assign hdr_take   = (state == IDLE) && word_fire && !hdr_bad && !flush;

  assign busy        = (state != IDLE);
  assign input_valid = input_valid_q;
  assign opcode      = opcode_q;
  assign data_in     = data_q;
  assign err         = err_q;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    state_next = state;
    hdr_bad    = 1'b0;
    unique case (state)
      IDLE: begin
        if (word_fire) begin
          if (hdr_nw == '0)          state_next = ISSUE;
          else if (hdr_nw <= MAX_NW) state_next = LOAD;
          else                       hdr_bad    = 1'b1;
        end
      end
      LOAD: begin
        if (word_fire && last_word) state_next = ISSUE;
      end
      ISSUE: begin
        if (input_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Abort wins over any word or header accepted in the same cycle.
    if (flush) begin
      state_next = IDLE;
      hdr_bad    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count         <= '0;
      nwords        <= '0;
      opcode_q      <= '0;
      data_q        <= '0;
      input_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else if (flush) begin
      count         <= '0;
      nwords        <= '0;
      opcode_q      <= '0;
      data_q        <= '0;
      input_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      input_valid_q <= (state_next == ISSUE);
      err_q         <= hdr_bad;
      if (hdr_take) begin
        opcode_q <= word_data[HDR_OPC_LSB +: OPC_W];
        data_q   <= '0;
        count    <= '0;
        nwords   <= hdr_nw;
      end else if (state == LOAD && word_fire) begin
        data_q[int'(count) * WORD_W +: WORD_W] <= word_data;
        count <= count + 1'b1;
      end
    end
  end

  // The core may sample the command on any cycle it is offered.
  a_hold_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (input_valid && !input_ready && !flush) |=> (input_valid && $stable(opcode) && $stable(data_in)));

  a_err_idle : assert property (@(posedge clk) disable iff (!rst_n)
    err |-> !busy);

endmodule

// File: tb/tb_aes_cmd_packer.sv
// Self-checking bench for aes_cmd_packer: directed table, corner sequences, random vs. transaction model.
module tb_aes_cmd_packer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         word_valid;
  logic         word_ready;
  logic [31:0]  word_data;
  logic         input_valid;
  logic         input_ready;
  logic [4:0]   opcode;
  logic [255:0] data_in;
  logic         busy;
  logic         err;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  aes_cmd_packer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .word_data   (word_data),
    .input_valid (input_valid),
    .input_ready (input_ready),
    .opcode      (opcode),
    .data_in     (data_in),
    .busy        (busy),
    .err         (err)
  );

  typedef struct {
    string        name;
    logic [31:0]  hdr;
    logic [255:0] pay;
    logic         exp_err;
    logic [4:0]   exp_opc;
    logic [255:0] exp_data;
  } vec_t;

  typedef struct {
    logic [4:0]   opc;
    logic [255:0] data;
  } cmd_t;

  vec_t         vecs[5];
  logic [31:0]  words_q[$];
  cmd_t         exp_q[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one word and return one cycle after it was accepted.
  task automatic push_word(input logic [31:0] w);
    int n;
    n = 0;
    word_valid = 1'b1;
    word_data  = w;
    while (!word_ready && n < 50) begin
      step();
      n++;
    end
    check("push.ready", word_ready, 1'b1);
    step();
    word_valid = 1'b0;
  endtask

  task automatic handshake(input string name);
    input_ready = 1'b1;
    step();
    input_ready = 1'b0;
    check({name, ".valid_drop"}, input_valid, 1'b0);
    check({name, ".idle"}, busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int           nw;
    int           obs_err;
    int           exp_err;
    int           cyc;
    logic         wf, cf;
    logic [4:0]   cur_opc;
    logic [255:0] cur_data;
    cmd_t         c;

    vecs[0] = '{"full8", 32'h0000_0800,
                256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111,
                1'b0, 5'd0,
                256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111};
    vecs[1] = '{"one", 32'h0000_0101, 256'h45, 1'b0, 5'd1, 256'h45};
    vecs[2] = '{"zero", 32'h0000_0002, 256'hFFFF, 1'b0, 5'd2, 256'h0};
    vecs[3] = '{"bad9", 32'h0000_0903, 256'h0, 1'b1, 5'd0, 256'h0};
    vecs[4] = '{"junkhdr", 32'hABCD_F2E7, {{6{32'hFFFF_FFFF}}, 32'h1234_5678, 32'hDEAD_BEEF},
                1'b0, 5'd7, 256'h12345678_DEADBEEF};

    rst_n = 1'b0; flush = 1'b0; word_valid = 1'b0; word_data = '0; input_ready = 1'b0;
    repeat (2) step();
    check("rst.valid", input_valid, 1'b0);
    check("rst.busy", busy, 1'b0);
    check("rst.err", err, 1'b0);
    check("rst.data", data_in, 256'h0);
    check("rst.opcode", opcode, 5'd0);
    check("rst.word_ready", word_ready, 1'b1);
    rst_n = 1'b1;
    step();

    // Directed table.
    for (int i = 0; i < 5; i++) begin
      nw = int'(vecs[i].hdr[11:8]);
      push_word(vecs[i].hdr);
      if (vecs[i].exp_err) begin
        check({vecs[i].name, ".err"}, err, 1'b1);
        check({vecs[i].name, ".busy"}, busy, 1'b0);
        check({vecs[i].name, ".novalid"}, input_valid, 1'b0);
        step();
        check({vecs[i].name, ".err_pulse"}, err, 1'b0);
        check({vecs[i].name, ".novalid2"}, input_valid, 1'b0);
        continue;
      end
      for (int k = 0; k < nw; k++) begin
        check($sformatf("%s.early%0d", vecs[i].name, k), input_valid, 1'b0);
        push_word(vecs[i].pay[k*32 +: 32]);
      end
      check({vecs[i].name, ".latency"}, input_valid, 1'b1);
      check({vecs[i].name, ".opcode"}, opcode, vecs[i].exp_opc);
      check({vecs[i].name, ".data"}, data_in, vecs[i].exp_data);
      for (int s = 0; s < 3; s++) begin
        step();
        check($sformatf("%s.hold_valid%0d", vecs[i].name, s), input_valid, 1'b1);
        check($sformatf("%s.hold_opc%0d", vecs[i].name, s), opcode, vecs[i].exp_opc);
        check($sformatf("%s.hold_data%0d", vecs[i].name, s), data_in, vecs[i].exp_data);
      end
      handshake(vecs[i].name);
    end

    // Flush mid-load, with a word offered in the flush cycle.
    push_word(32'h0000_0800);
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(0, 3)) step();
      push_word(32'hC0DE_0000 + k);
    end
    check("flush.busy_before", busy, 1'b1);
    flush = 1'b1; word_valid = 1'b1; word_data = 32'h0000_0BAD;
    step();
    flush = 1'b0; word_valid = 1'b0;
    check("flush.busy", busy, 1'b0);
    check("flush.data", data_in, 256'h0);
    check("flush.opcode", opcode, 5'd0);
    check("flush.valid", input_valid, 1'b0);
    check("flush.err", err, 1'b0);
    push_word(32'h0000_0101);
    push_word(32'h0000_00AA);
    check("post_flush.valid", input_valid, 1'b1);
    check("post_flush.data", data_in, 256'hAA);
    handshake("post_flush");

    // Flush beats a header accepted in the same cycle.
    flush = 1'b1; word_valid = 1'b1; word_data = 32'h0000_0002;
    step();
    flush = 1'b0; word_valid = 1'b0;
    step();
    check("flush_hdr.valid", input_valid, 1'b0);
    check("flush_hdr.busy", busy, 1'b0);

    // Flush in ISSUE together with input_ready.
    input_ready = 1'b1;
    step();
    input_ready = 1'b0;
    check("ready_idle.ignored", busy, 1'b0);
    push_word(32'h0000_0004);
    check("issue_flush.valid_before", input_valid, 1'b1);
    flush = 1'b1; input_ready = 1'b1;
    step();
    flush = 1'b0; input_ready = 1'b0;
    check("issue_flush.valid", input_valid, 1'b0);
    check("issue_flush.busy", busy, 1'b0);

    // Asynchronous reset mid-command.
    push_word(32'h0000_0305);
    push_word(32'h0000_1234);
    #2 rst_n = 1'b0;
    #1;
    check("midrst.busy", busy, 1'b0);
    check("midrst.data", data_in, 256'h0);
    check("midrst.opcode", opcode, 5'd0);
    check("midrst.word_ready", word_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Random traffic against an ordered command model.
    exp_err = 0;
    obs_err = 0;
    for (int n = 0; n < 40; n++) begin
      logic [31:0]  hdr;
      logic [255:0] d;
      int           r;
      r   = int'($urandom_range(0, 9));
      nw  = (r == 9) ? int'($urandom_range(9, 15)) : r;
      hdr = $urandom;
      hdr[4:0]  = 5'($urandom_range(0, 31));
      hdr[11:8] = 4'(nw);
      words_q.push_back(hdr);
      if (nw > 8) begin
        exp_err++;
      end else begin
        d = '0;
        for (int k = 0; k < nw; k++) begin
          logic [31:0] w;
          w = $urandom;
          d[k*32 +: 32] = w;
          words_q.push_back(w);
        end
        c.opc  = hdr[4:0];
        c.data = d;
        exp_q.push_back(c);
      end
    end

    cyc = 0;
    while ((words_q.size() > 0 || exp_q.size() > 0) && cyc < 20000) begin
      word_valid  = (words_q.size() > 0) && ($urandom_range(0, 3) != 0);
      word_data   = (words_q.size() > 0) ? words_q[0] : 32'h0;
      input_ready = ($urandom_range(0, 2) != 0);
      wf       = word_valid && word_ready;
      cf       = input_valid && input_ready;
      cur_opc  = opcode;
      cur_data = data_in;
      step();
      cyc++;
      if (err) obs_err++;
      if (wf) void'(words_q.pop_front());
      if (cf) begin
        if (exp_q.size() == 0) begin
          check("rand.unexpected_cmd", 1'b1, 1'b0);
        end else begin
          c = exp_q.pop_front();
          check("rand.opcode", cur_opc, c.opc);
          check("rand.data", cur_data, c.data);
        end
      end
    end
    word_valid = 1'b0;
    input_ready = 1'b0;
    step();
    check("rand.drain", exp_q.size(), 0);
    check("rand.err_count", obs_err, exp_err);
    check("rand.idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
